// File: rtl/pixel_line_fifo.sv
// Pixel sample line buffer between ADC capture and readout.
// FWFT read port, sticky overflow and saturating drop counter.
module pixel_line_fifo #(
    parameter int DATA_W    = 14,
    parameter int DEPTH     = 1024,
    parameter int AF_THRESH = 896,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_wr_en,
    input  logic [DATA_W-1:0]          fifo_wr_data,
    input  logic                       wr_sof,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W:0]            rd_data,
    output logic                       overflow,
    input  logic                       overflow_clr,
    output logic [CNT_W-1:0]           drop_count,
    input  logic                       flush
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);

    logic [DATA_W:0]   mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              af_q, af_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;

    logic              wr_acc;
    logic              pop;
    logic              drop;

    // Next-state for pointers, occupancy, flags and drop tracking
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        wr_acc       = 1'b0;
        pop          = 1'b0;
        drop         = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_acc = fifo_wr_en && !full_q;
            drop   = fifo_wr_en && full_q;
            pop    = (level_q != '0) && rd_ready;
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (wr_acc && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !wr_acc) begin
                level_d = level_q - LW'(1);
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_clr) begin
                drop_count_d = CNT_W'(1);
            end else if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + CNT_W'(1);
            end
        end else if (overflow_clr) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end

        full_d  = (level_d == DEPTH_L);
        empty_d = (level_d == '0);
        af_d    = (level_d >= AF_L);
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            af_q         <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            af_q         <= af_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Sample storage; contents are only observable while level is nonzero
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= {wr_sof, fifo_wr_data};
        end
    end

    assign rd_valid    = (level_q != '0);
    assign rd_data     = rd_valid ? mem[rd_ptr_q] : '0;
    assign level       = level_q;
    assign fifo_full   = full_q;
    assign fifo_empty  = empty_q;
    assign almost_full = af_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;

endmodule

// File: doc/pixel_line_fifo.md
Name: pixel_line_fifo

Overview:
- Buffers digitized pixel samples between the panel controller's ADC capture path and the host/readout interface.
- Consumes the controller's fifo_wr_en / fifo_wr_data stream and returns fifo_full / fifo_empty status to it.
- Presents words on a first-word-fall-through valid/ready read port, tagged with start-of-frame.
- Tracks overflow (dropped samples) for the controller's int_fifo_overflow interrupt.

Parameters:
DATA_W, 14, pixel sample width (matches adc_data / fifo_wr_data)
DEPTH, 1024, storage entries; power of two, minimum 4
AF_THRESH, 896, level at or above which almost_full asserts; 1 to DEPTH-1
CNT_W, 16, width of the saturating drop counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
fifo_wr_en  in  1  write strobe from panel controller, one sample per asserted cycle
fifo_wr_data  in  DATA_W  pixel sample
wr_sof  in  1  qualifies fifo_wr_en; marks the sample as first pixel of a frame
fifo_full  out  1  level == DEPTH
fifo_empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
level  out  $clog2(DEPTH)+1  current occupancy
rd_valid  out  1  rd_data holds a valid word
rd_ready  in  1  consumer accepts rd_data when rd_valid && rd_ready
rd_data  out  DATA_W+1  {sof_tag, sample}
overflow  out  1  sticky; a write was dropped
overflow_clr  in  1  single-cycle clear of overflow and drop_count
drop_count  out  CNT_W  number of dropped writes, saturating at all-ones
flush  in  1  synchronous discard of all stored words

Behaviour:
Reset (rst_n low, asynchronous):
- Pointers and level cleared; overflow = 0; drop_count = 0.
- Outputs: fifo_empty = 1, fifo_full = 0, almost_full = 0, level = 0, rd_valid = 0.
- rd_data = 0 while empty.
- Reset mid-operation discards all contents; no partial word survives.

Storage and read port:
- Circular buffer addressed by wr_ptr / rd_ptr, each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
- Occupancy is held in a separate level register, not derived from the pointers.
- First-word-fall-through: rd_data = mem[rd_ptr] when level > 0, else 0.
- rd_valid = (level != 0).
- A word written at edge N is visible on rd_valid/rd_data after edge N; latency is 1 cycle from the write strobe.
- Pop occurs on a cycle with rd_valid && rd_ready: rd_ptr increments at that edge. rd_ready while empty has no effect.
- rd_data must stay stable while rd_valid && !rd_ready.

Write rules:
- Accept when fifo_wr_en && !fifo_full: mem[wr_ptr] <= {wr_sof, fifo_wr_data}, then wr_ptr increments.
- Write while fifo_full is dropped, even if a pop occurs in the same cycle, so full behaviour is deterministic.
- A dropped write sets overflow and increments drop_count, which saturates at all-ones.
- Contents and pointers are unchanged on a dropped write.

Level update (one edge):
- +1 on accepted write only.
- −1 on pop only.
- Unchanged when both occur, or when neither occurs.
- Simultaneous accepted write and pop at level 1: level stays 1 and rd_data moves to the new word.

Flags:
- fifo_full, fifo_empty and almost_full are registered, derived from the next-level value so they are exact in the same cycle as level.
- No off-by-one between a flag and level is permitted.

Flush:
- Synchronous. Next edge: both pointers = 0, level = 0, empty.
- Priority over a write or pop in the same cycle: that write is not stored and not counted as a drop.
- overflow and drop_count are unaffected by flush.

Overflow clear:
- overflow_clr clears overflow and drop_count at the next edge.
- If a drop occurs in the same cycle as overflow_clr, the drop wins: overflow = 1, drop_count = 1.

Arithmetic:
- All pointer arithmetic is modulo DEPTH.
- level never exceeds DEPTH and never underflows; the verifier asserts both invariants every cycle.

Test Plan:
- Reset → fifo_empty=1, level=0, rd_valid=0, overflow=0. Then write 0x0001 with wr_sof=1 → next cycle rd_valid=1, rd_data=0x4001, level=1.
- Write 0x0000..0x03FF (1024 words) with rd_ready=0 → fifo_full=1, level=1024, almost_full first asserted in the cycle after the 896th write. Extra write 0x1234 → overflow=1, drop_count=1, contents unchanged. Drain → 0x0000..0x03FF in order.
- Run 3000 continuous writes with rd_ready=1 → level stays 1 after the first word, read order matches write order across pointer wrap, no drops.
- Fill to full, then assert fifo_wr_en and rd_ready in the same cycle → pop occurs, write dropped: level=1023, drop_count incremented.
- At level 500 assert flush together with fifo_wr_en → next cycle level=0, fifo_empty=1, drop_count unchanged. overflow_clr together with a full-write → overflow=1, drop_count=1.
- Hold rd_ready=0 for 10 cycles with rd_valid=1 → rd_data stable. Deassert rst_n mid-stream at level 37 → all outputs at reset values immediately, without waiting for a clock edge.
